// File: rtl/port_width_adapter_pkg.sv
// port_width_pkg: shared types and width helpers for port_width_adapter.
//   adapt_word : applies the port-connection width rule (zero-extend/pass/truncate)
//   is_lossy   : 1 when truncation discards a bit that is definitely 1
//   sat_max    : all-ones value of a given width (counter saturation point)
// Helpers work on MAX_W-bit containers; callers size-cast in and out.
package port_width_pkg;

  localparam int MAX_W     = 64;
  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_FULL1 = 2'd1,
    SB_FULL2 = 2'd2
  } sb_state_e;

  // Keep only the bits that exist on both sides; upper bits become 0.
  // X/Z in kept bits is preserved as-is.
  function automatic logic [MAX_W-1:0] adapt_word(input logic [MAX_W-1:0] in,
                                                  input int in_w, input int out_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < in_w && i < out_w) r[i] = in[i];
    return r;
  endfunction

  // Only a bit that is known 1 counts; X/Z in the discarded range is not lossy.
  function automatic logic is_lossy(input logic [MAX_W-1:0] in,
                                    input int in_w, input int out_w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_W; i++)
      if (i >= out_w && i < in_w && in[i] === 1'b1) r = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/port_width_adapter_if.sv
// port_width_adapter_if: one valid/ready stream of W-bit words.
//   master drives valid/data and samples ready; slave the reverse.
interface port_width_adapter_if #(parameter int W = 1);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/port_width_adapter_skid_buffer2.sv
// skid_buffer2: 2-entry valid/ready register stage, W-bit payload.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake, driven from main register
// in_ready is decoded from the state register only, so it never depends
// combinationally on out_ready. The skid register is written only when main
// is occupied and downstream stalls.
module skid_buffer2
  import port_width_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_e    state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         accept, xfer;
  logic         load_main, load_skid, pop_skid;

  assign in_ready  = (state_q != SB_FULL2);
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SB_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state_q)
      SB_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = SB_FULL1;
        end
      end
      SB_FULL1: begin
        if (accept && xfer) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = SB_FULL2;
        end else if (xfer) begin
          state_d   = SB_EMPTY;
        end
      end
      SB_FULL2: begin
        if (xfer) begin
          pop_skid = 1'b1;
          state_d  = SB_FULL1;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)     main_q <= in_data;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= in_data;
    end
  end

endmodule

// File: rtl/port_width_adapter.sv
// port_width_adapter: registered IN_W -> OUT_W stream stage.
//   clk, reset  : clock, synchronous active-high reset
//   up (slave)  : IN_W-bit input stream (valid/ready/data)
//   dn (master) : OUT_W-bit output stream, registered, 1-cycle latency
//   trunc_count : saturating count of accepted words that lost a set bit
//   trunc_flag  : sticky, set with the first counted lossy accept
// Width rule follows Verilog port connection: zero-extend, pass or truncate.
module port_width_adapter
  import port_width_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  port_width_adapter_if.slave  up,
  port_width_adapter_if.master dn,
  output logic [CNT_W-1:0]     trunc_count,
  output logic                 trunc_flag
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_max(CNT_W));

  logic [MAX_W-1:0] in_ext;
  logic [OUT_W-1:0] adapted;
  logic             lossy;
  logic             accept;
  logic [OUT_W:0]   buf_out;
  logic             lossy_tag_unused;

  assign in_ext  = MAX_W'(up.data);
  assign adapted = OUT_W'(adapt_word(in_ext, IN_W, OUT_W));
  assign lossy   = is_lossy(in_ext, IN_W, OUT_W);
  assign accept  = up.valid && up.ready;

  // Payload is {lossy tag, adapted word}; the tag travels with its word so a
  // downstream observer can be added without re-deriving it.
  skid_buffer2 #(.W(OUT_W + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (up.valid),
    .in_ready  (up.ready),
    .in_data   ({lossy, adapted}),
    .out_valid (dn.valid),
    .out_ready (dn.ready),
    .out_data  (buf_out)
  );

  assign dn.data          = buf_out[OUT_W-1:0];
  assign lossy_tag_unused = buf_out[OUT_W];

  // Counted at the accept edge from the live input, so count/flag move in
  // the same cycle as the word enters the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      trunc_count <= '0;
      trunc_flag  <= 1'b0;
    end else if (accept && lossy && trunc_count != CNT_SAT) begin
      trunc_count <= trunc_count + CNT_W'(1);
      trunc_flag  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_port_width_adapter.sv
module tb_port_width_adapter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // A: 3->2 cnt8, B: 1->2, C: 2->2, D: 3->2 cnt2
  port_width_adapter_if #(.W(3)) a_up();
  port_width_adapter_if #(.W(2)) a_dn();
  port_width_adapter_if #(.W(1)) b_up();
  port_width_adapter_if #(.W(2)) b_dn();
  port_width_adapter_if #(.W(2)) c_up();
  port_width_adapter_if #(.W(2)) c_dn();
  port_width_adapter_if #(.W(3)) d_up();
  port_width_adapter_if #(.W(2)) d_dn();

  logic [7:0] a_cnt, b_cnt, c_cnt;
  logic [1:0] d_cnt;
  logic       a_flag, b_flag, c_flag, d_flag;

  port_width_adapter #(.IN_W(3), .OUT_W(2), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .up(a_up), .dn(a_dn), .trunc_count(a_cnt), .trunc_flag(a_flag));
  port_width_adapter #(.IN_W(1), .OUT_W(2), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .up(b_up), .dn(b_dn), .trunc_count(b_cnt), .trunc_flag(b_flag));
  port_width_adapter #(.IN_W(2), .OUT_W(2), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .up(c_up), .dn(c_dn), .trunc_count(c_cnt), .trunc_flag(c_flag));
  port_width_adapter #(.IN_W(3), .OUT_W(2), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .up(d_up), .dn(d_dn), .trunc_count(d_cnt), .trunc_flag(d_flag));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b1;
    b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b1;
    c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b1;
    d_up.valid = 1'b0; d_up.data = '0; d_dn.ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] d;
    logic       ordy;
    logic       ov;
    logic [1:0] od;
    logic       ir;
    logic [7:0] cnt;
    logic       flag;
  } vec_t;

  function automatic vec_t mk(input int v, input int d, input int ordy, input int ov,
                              input int od, input int ir, input int cnt, input int flag);
    vec_t r;
    r.v = v[0]; r.d = d[2:0]; r.ordy = ordy[0];
    r.ov = ov[0]; r.od = od[1:0]; r.ir = ir[0]; r.cnt = cnt[7:0]; r.flag = flag[0];
    return r;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [2:0] xv;
    logic [1:0] rx[4];
    int         got, idx;
    logic       acc, xfer;
    int         dw[6];
    int         dc[6];
    logic [63:0] exp_x;

    //            v  d  ordy ov od ir cnt flag
    tbl[0]  = mk(1, 0, 1,   1, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 1,   1, 1, 1, 0, 0);
    tbl[2]  = mk(1, 2, 1,   1, 2, 1, 0, 0);
    tbl[3]  = mk(1, 3, 1,   1, 3, 1, 0, 0);
    tbl[4]  = mk(1, 4, 1,   1, 0, 1, 1, 1);
    tbl[5]  = mk(1, 5, 1,   1, 1, 1, 2, 1);
    tbl[6]  = mk(1, 6, 1,   1, 2, 1, 3, 1);
    tbl[7]  = mk(1, 7, 1,   1, 3, 1, 4, 1);
    tbl[8]  = mk(0, 0, 1,   0, 0, 1, 4, 1);
    tbl[9]  = mk(1, 5, 0,   1, 1, 1, 5, 1);  // empty -> full1, stalled
    tbl[10] = mk(1, 2, 0,   1, 1, 0, 5, 1);  // into skid, ready drops
    tbl[11] = mk(1, 7, 0,   1, 1, 0, 5, 1);  // not accepted, not counted
    tbl[12] = mk(0, 0, 1,   1, 2, 1, 5, 1);  // skid -> main
    tbl[13] = mk(0, 0, 1,   0, 0, 1, 5, 1);

    idle_all();
    tick();
    do_reset();

    // reset state
    check("rst_out_valid", 64'(a_dn.valid), 64'd0);
    check("rst_out_data",  64'(a_dn.data),  64'd0);
    check("rst_in_ready",  64'(a_up.ready), 64'd1);
    check("rst_cnt",       64'(a_cnt),      64'd0);
    check("rst_flag",      64'(a_flag),     64'd0);

    // table: 3->2 sweep then stall sequence
    for (int i = 0; i < 14; i++) begin
      a_up.valid = tbl[i].v;
      a_up.data  = tbl[i].d;
      a_dn.ready = tbl[i].ordy;
      tick();
      check($sformatf("tbl%0d_ov", i), 64'(a_dn.valid), 64'(tbl[i].ov));
      if (tbl[i].ov) check($sformatf("tbl%0d_od", i), 64'(a_dn.data), 64'(tbl[i].od));
      check($sformatf("tbl%0d_ir", i),   64'(a_up.ready), 64'(tbl[i].ir));
      check($sformatf("tbl%0d_cnt", i),  64'(a_cnt),      64'(tbl[i].cnt));
      check($sformatf("tbl%0d_flag", i), 64'(a_flag),     64'(tbl[i].flag));
    end

    // reset while FULL2 holds two words (5,6 -> 1,2)
    do_reset();
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 3'd5; tick();
    a_up.data = 3'd6; tick();
    check("f2_in_ready", 64'(a_up.ready), 64'd0);
    check("f2_cnt",      64'(a_cnt),      64'd2);
    a_up.data = 3'd7; a_dn.ready = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; a_up.valid = 1'b0;
    check("f2rst_out_valid", 64'(a_dn.valid), 64'd0);
    check("f2rst_in_ready",  64'(a_up.ready), 64'd1);
    check("f2rst_cnt",       64'(a_cnt),      64'd0);
    check("f2rst_flag",      64'(a_flag),     64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("f2rst_drain%0d", i), 64'(a_dn.valid), 64'd0);
    end

    // unknown bit in the discarded range
    do_reset();
    xv = 3'bx01;
    exp_x = (xv[2] === 1'b1) ? 64'd1 : 64'd0;
    a_up.valid = 1'b1; a_up.data = xv;
    tick();
    a_up.valid = 1'b0;
    check("x_out_data", 64'(a_dn.data), 64'd1);
    check("x_cnt",      64'(a_cnt),     exp_x);

    // B: 1 -> 2 zero-extend
    do_reset();
    b_up.valid = 1'b1; b_up.data = 1'b1; tick();
    check("ext_out1", 64'(b_dn.data), 64'd1);
    check("ext_ov1",  64'(b_dn.valid), 64'd1);
    b_up.data = 1'b0; tick();
    check("ext_out0", 64'(b_dn.data), 64'd0);
    b_up.valid = 1'b0; tick();
    check("ext_cnt",  64'(b_cnt),  64'd0);
    check("ext_flag", 64'(b_flag), 64'd0);

    // C: 2 -> 2, stall 3 cycles, then drain; order and completeness
    do_reset();
    got = 0; idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_up.valid = (idx < 4);
      c_up.data  = 2'(idx);
      c_dn.ready = (cyc >= 3);
      acc  = c_up.valid && c_up.ready;
      xfer = c_dn.valid && c_dn.ready;
      if (xfer) begin
        if (got < 4) rx[got] = c_dn.data;
        got++;
      end
      tick();
      if (acc) idx++;
      if (cyc == 1) check("stall_in_ready", 64'(c_up.ready), 64'd0);
      if (cyc == 2) check("stall_hold_data", 64'(c_dn.data), 64'd0);
    end
    c_up.valid = 1'b0;
    check("stream_count", 64'(got), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got) check($sformatf("stream_word%0d", i), 64'(rx[i]), 64'(i));
    check("stream_cnt", 64'(c_cnt), 64'd0);

    // D: CNT_W=2 saturation
    do_reset();
    dw = '{4, 5, 6, 7, 4, 5};
    dc = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      d_up.valid = 1'b1; d_up.data = 3'(dw[i]);
      tick();
      check($sformatf("sat_cnt%0d", i), 64'(d_cnt),    64'(dc[i]));
      check($sformatf("sat_od%0d", i),  64'(d_dn.data), 64'(dw[i] & 3));
    end
    d_up.valid = 1'b0;
    check("sat_flag", 64'(d_flag), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/port_width_adapter.md
# port_width_adapter

Registered stream stage that sits directly upstream of the 2-bit `copy` datapath block and its width-mismatch variants. It accepts IN_W-bit words over a valid/ready handshake and presents OUT_W-bit words, zero-extending or truncating under Verilog port-connection rules. Outputs are registered, and a 2-entry skid buffer sustains full throughput. Truncation events that discard set bits are counted and flagged.

## Interface
- IN_W, 3, upstream word width (>=1)
- OUT_W, 2, downstream word width (>=1)
- CNT_W, 8, truncation counter width (>=1)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word present
- in_ready  output  1  stage can accept a word
- in_data  input  IN_W  upstream word
- out_valid  output  1  registered word present
- out_ready  input  1  downstream accepts the word
- out_data  output  OUT_W  adapted word
- trunc_count  output  CNT_W  saturating count of lossy accepts
- trunc_flag  output  1  sticky; set on the first lossy accept

## Operation
- Width rule, applied on accept:
  - OUT_W > IN_W: zero-extend, so out_data = {0…, in_data}.
  - OUT_W == IN_W: pass through unchanged.
  - OUT_W < IN_W: keep in_data[OUT_W-1:0].
- Lossy accept: OUT_W < IN_W and the reduction-OR of in_data[IN_W-1:OUT_W] is 1'b1. X or Z in the discarded bits is not lossy.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage is a main register (drives out_*) plus one skid register.
  - EMPTY: main invalid. An accept loads main.
  - FULL1: main valid, skid empty.
    - Accept with an output transfer: reload main.
    - Accept without an output transfer: load skid and go to FULL2.
    - Output transfer without an accept: go to EMPTY.
  - FULL2: both valid, in_ready = 0.
    - An output transfer moves skid to main and returns to FULL1.
- in_ready = !skid_valid. It is a registered state bit, not combinationally dependent on out_ready.
- Order is preserved. No word is dropped or duplicated.
- trunc_count increments by 1 on each lossy accept and saturates at 2^CNT_W-1, with no wrap.
- trunc_flag sets with the first increment and is cleared only by reset.
- When OUT_W >= IN_W, trunc_count and trunc_flag stay 0.

## Timing
- Reset is sampled at the posedge of clk. On the following cycle:
  - out_valid = 0, out_data = 0
  - skid empty, so in_ready = 1
  - trunc_count = 0, trunc_flag = 0
- A handshake occurring in a cycle where reset is high is ignored.
- Reset asserted mid-operation discards both stored words. They never appear at the output.
- Latency: a word accepted at edge N is on out_data with out_valid = 1 after edge N, i.e. one cycle.
- Throughput: 1 word/cycle while out_ready = 1.
- Simultaneous accept and output transfer in FULL1 keeps in_ready = 1 and does not touch the skid register.
- out_data and out_valid are held stable while out_valid && !out_ready.
- trunc_count and trunc_flag update at the same edge as the lossy accept.

## Structure
- Shared package `port_width_pkg`:
  - function `adapt_word(in, IN_W, OUT_W)` returning the adapted word.
  - function `is_lossy`.
  - localparam for the counter saturation value.
- Sub-module `skid_buffer2`: generic 2-entry valid/ready register stage parameterized on data width. It carries OUT_W data plus a 1-bit lossy tag.
- The top level instantiates `skid_buffer2` and owns the width functions and the counter.

## Test plan
- Default widths (3→2), in_data swept 0..7 with out_ready = 1 → out_data = 0,1,2,3,0,1,2,3 one cycle after each accept; trunc_count ends at 4; trunc_flag = 1.
- IN_W = 1, OUT_W = 2, in_data = 1 then 0 → out_data = 2'b01 then 2'b00; trunc_count stays 0.
- IN_W = OUT_W = 2, stream 0..3 with out_ready held 0 for 3 cycles → in_ready drops after 2 accepts. On release, output order is 0,1,2,3 with no loss.
- Reset asserted while in FULL2 holding 1 and 2 → next cycle out_valid = 0, in_ready = 1, trunc_count = 0. Words 1 and 2 never appear at the output.
- CNT_W = 2, six lossy words (4,5,6,7,4,5) → trunc_count saturates at 3.
- in_data = 3'bx01 at 3→2 → out_data = 2'b01, trunc_count unchanged.
